inst_axi_rd_bridge: RTL and testbench
=====================================

# inst_axi_rd_bridge

Converts the fetch stage's SRAM-like instruction request/response handshake into single-beat AXI4 read transactions. It sits directly downstream of the instruction fetch SRAM-like master and upstream of the top-level AXI crossbar/arbiter. It carries one outstanding transaction at a time. It returns `inst_rdata`/`inst_data_ok` in the form the fetch stage latches.

## Interface
- `AXI_ID`, default 4'd0: constant driven on `arid`.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `inst_req`  in  1  fetch request valid.
- `inst_wr`  in  1  write flag; ignored, every request is a read.
- `inst_size`  in  2  log2 bytes; 2'b10 for instruction fetch.
- `inst_addr`  in  32  fetch address.
- `inst_wdata`  in  32  ignored.
- `inst_addr_ok`  out  1  request accepted this cycle.
- `inst_data_ok`  out  1  `inst_rdata` valid this cycle.
- `inst_rdata`  out  32  instruction word.
- `inst_bus_err`  out  1  pulses with `inst_data_ok` when `rresp`≠0.
- `arid`  out  4  read ID, equals `AXI_ID`.
- `araddr`  out  32  latched `inst_addr`.
- `arlen`  out  8  constant 0.
- `arsize`  out  3  {1'b0, latched `inst_size`}.
- `arburst`  out  2  constant 2'b01.
- `arlock`  out  2  constant 0.
- `arcache`  out  4  constant 0.
- `arprot`  out  3  constant 0.
- `arvalid`  out  1  AR valid.
- `arready`  in  1  AR ready.
- `rid`  in  4  ignored; this is a dedicated channel.
- `rdata`  in  32  read data.
- `rresp`  in  2  read response.
- `rlast`  in  1  last beat.
- `rvalid`  in  1  R valid.
- `rready`  out  1  R ready.

## Operation
- The FSM has three states: IDLE, ADDR and DATA. Reset state is IDLE.
- **IDLE**
  - `inst_addr_ok = inst_req`, combinational.
  - On `inst_req`, latch `inst_addr` and `inst_size` into `addr_r`/`size_r`, then go to ADDR.
- **ADDR**
  - `arvalid=1`. `araddr`/`arsize` come from the latched registers and stay stable until `arready`.
  - On `arready`, go to DATA.
- **DATA**
  - `rready=1`.
  - On `rvalid & rlast`: `inst_data_ok=1`, `inst_rdata=rdata` (combinational pass-through), `inst_bus_err=(rresp!=0)`, then go to IDLE.
  - `rvalid` with `rlast=0` is consumed and dropped; the FSM stays in DATA. This is a protocol-violation tolerance.
- Output defaults:
  - `inst_data_ok=0` and `inst_bus_err=0` outside DATA, or when `rvalid`/`rlast` is low.
  - `inst_rdata=rdata` at all times; it is meaningful only when `inst_data_ok` is high.
- Request acceptance:
  - `inst_addr_ok` is never asserted outside IDLE, so new requests wait.
  - The fetch master keeps `inst_req` and `inst_addr` stable until it sees `inst_addr_ok`.
- Bus errors: data is still returned on a bus error. The exception decision belongs to later stages.

## Timing
- Reset values: state IDLE; `arvalid=0`, `rready=0`, `inst_addr_ok=0`, `inst_data_ok=0`, `inst_bus_err=0`; `addr_r=0`, `size_r=0`.
- Best-case latency with `arready` and `rvalid` already high:
  - cycle 0: `inst_addr_ok`.
  - cycle 1: `arvalid` & `arready`.
  - cycle 2: `rvalid` → `inst_data_ok`.
  - cycle 3: IDLE, next `inst_addr_ok` possible.
  - Peak throughput: one fetch per 3 cycles.
- Each extra cycle of `arready` low or `rvalid` low adds exactly one cycle.
- `arvalid` never deasserts before `arready`, except on `rst`.
- `rready` is high only in DATA.
- Reset mid-transaction: the next cycle is IDLE with all outputs at reset values. A late R beat arriving in IDLE is not accepted, because `rready=0`.
- Simultaneous events:
  - `inst_req` arriving in the same cycle as `inst_data_ok` is not accepted that cycle; it is accepted the following cycle in IDLE.
  - `arready` asserted in ADDR together with `rvalid` is not a valid case, because R follows AR. `rvalid` in ADDR is ignored.

## Test plan
- **Reset:** assert `rst` for 2 cycles with `inst_req=1` → `arvalid=0`, `rready=0`, `inst_addr_ok=0`, `inst_data_ok=0`; first `inst_addr_ok` occurs the cycle after `rst` falls.
- **Zero-wait fetch:** `inst_addr=32'hbfc0_0000`, `inst_size=2`, slave returns `rdata=32'h3c08_bfc0`, `rresp=0`, `rlast=1` → `araddr=32'hbfc0_0000`, `arsize=3'b010`, `arlen=0`, `arburst=01`; `inst_data_ok` at cycle 2 with that data; `inst_bus_err=0`.
- **Backpressure:** `arready` low 3 cycles, then `rvalid` delayed 4 cycles → `arvalid`/`araddr` stable throughout; `inst_data_ok` at cycle 9; no second `inst_addr_ok` in between.
- **Back-to-back fetches:** `inst_req` held high for `bfc0_0000` then `bfc0_0004` → `inst_addr_ok` at cycles 0 and 3, `inst_data_ok` at cycles 2 and 5, second `araddr=32'hbfc0_0004`.
- **Bus error:** `rresp=2'b10` → `inst_data_ok=1` and `inst_bus_err=1` for exactly one cycle; FSM returns to IDLE.
- **Reset mid-operation:** assert `rst` in DATA while `rvalid=0`, then drive `rvalid=1` after reset → `rready=0`, no `inst_data_ok`; a following request completes normally.

Source files
------------

// File: rtl/inst_axi_rd_bridge.sv
// Bridges the fetch stage's SRAM-like request/response handshake onto single-beat
// AXI4 reads, with one transaction in flight at a time.
module inst_axi_rd_bridge #(
    parameter logic [3:0] AXI_ID = 4'd0
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    output logic        inst_bus_err,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;

    // Fetch never writes and the R channel is dedicated, so these carry no information.
    logic unused_inputs;
    assign unused_inputs = ^{inst_wr, inst_wdata, rid};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= 32'd0;
            size_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        size_d       = size_q;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_bus_err = 1'b0;
        arvalid      = 1'b0;
        rready       = 1'b0;
        // Handshake outputs are held at their reset values while rst is high.
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    inst_addr_ok = inst_req;
                    if (inst_req) begin
                        addr_d  = inst_addr;
                        size_d  = inst_size;
                        state_d = ADDR;
                    end
                end
                ADDR: begin
                    arvalid = 1'b1;
                    if (arready) begin
                        state_d = DATA;
                    end
                end
                DATA: begin
                    rready = 1'b1;
                    // Non-last beats are accepted and discarded.
                    if (rvalid && rlast) begin
                        inst_data_ok = 1'b1;
                        inst_bus_err = (rresp != 2'b00);
                        state_d      = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign inst_rdata = rdata;
    assign arid       = AXI_ID;
    assign araddr     = addr_q;
    assign arlen      = 8'd0;
    assign arsize     = {1'b0, size_q};
    assign arburst    = 2'b01;
    assign arlock     = 2'b00;
    assign arcache    = 4'd0;
    assign arprot     = 3'd0;

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Bench for inst_axi_rd_bridge: directed fetch scenarios plus randomized traffic,
// checked every cycle against a transaction-level model of the bridge.
module tb_inst_axi_rd_bridge;

    typedef logic [31:0] q32_t[$];

    localparam logic [3:0] TB_ID = 4'd5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_req = 1'b0;
    logic        inst_wr = 1'b0;
    logic [1:0]  inst_size = 2'd0;
    logic [31:0] inst_addr = 32'd0;
    logic [31:0] inst_wdata = 32'd0;
    logic        inst_addr_ok, inst_data_ok, inst_bus_err;
    logic [31:0] inst_rdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst, arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid, rready;
    logic        arready = 1'b0;
    logic [3:0]  rid = 4'd0;
    logic [31:0] rdata = 32'd0;
    logic [1:0]  rresp = 2'd0;
    logic        rlast = 1'b0;
    logic        rvalid = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    bit last_exp_acc = 1'b0;

    // Event logs taken from the DUT outputs, used by the directed literal checks.
    q32_t acc_q, dok_q, berr_q, ara_q, ars_q, rd_q;

    always #5 clk = ~clk;

    inst_axi_rd_bridge #(.AXI_ID(TB_ID)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .inst_rdata(inst_rdata), .inst_bus_err(inst_bus_err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
        else
            n_pass++;
    endtask

    function automatic logic [31:0] qat(input q32_t q, input int i);
        return (i < q.size()) ? q[i] : 32'hdead_beef;
    endfunction

    task automatic clear_logs();
        acc_q.delete(); dok_q.delete(); berr_q.delete();
        ara_q.delete(); ars_q.delete(); rd_q.delete();
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Model: a request is "outstanding" from acceptance until its last R beat;
    // its address phase is done once AR has handshaked.
    initial begin
        bit          m_busy = 1'b0;
        bit          m_ar_done = 1'b0;
        logic [31:0] m_addr = 32'd0;
        logic [1:0]  m_size = 2'd0;
        bit e_acc, e_arv, e_rr, e_dok, e_berr;
        forever begin
            @(negedge clk);
            e_acc  = !rst && !m_busy && inst_req;
            e_arv  = !rst && m_busy && !m_ar_done;
            e_rr   = !rst && m_busy && m_ar_done;
            e_dok  = e_rr && rvalid && rlast;
            e_berr = e_dok && (rresp != 2'b00);

            chk("inst_addr_ok", 32'(inst_addr_ok), 32'(e_acc));
            chk("arvalid", 32'(arvalid), 32'(e_arv));
            chk("rready", 32'(rready), 32'(e_rr));
            chk("inst_data_ok", 32'(inst_data_ok), 32'(e_dok));
            chk("inst_bus_err", 32'(inst_bus_err), 32'(e_berr));
            if (e_arv) begin
                chk("araddr", araddr, m_addr);
                chk("arsize", 32'(arsize), 32'({1'b0, m_size}));
                chk("arid", 32'(arid), 32'(TB_ID));
                chk("arlen", 32'(arlen), 32'd0);
                chk("arburst", 32'(arburst), 32'd1);
                chk("arlock_cache_prot", 32'({arlock, arcache, arprot}), 32'd0);
            end
            if (e_dok) chk("inst_rdata", inst_rdata, rdata);

            if (inst_addr_ok) acc_q.push_back(32'(cyc));
            if (arvalid && arready) begin
                ara_q.push_back(araddr);
                ars_q.push_back(32'(arsize));
            end
            if (inst_data_ok) begin
                dok_q.push_back(32'(cyc));
                rd_q.push_back(inst_rdata);
            end
            if (inst_bus_err) berr_q.push_back(32'(cyc));

            if (rst) begin
                m_busy = 1'b0; m_ar_done = 1'b0; m_addr = 32'd0; m_size = 2'd0;
            end else if (e_acc) begin
                m_busy = 1'b1; m_ar_done = 1'b0; m_addr = inst_addr; m_size = inst_size;
            end else if (e_arv && arready) begin
                m_ar_done = 1'b1;
            end else if (e_dok) begin
                m_busy = 1'b0;
            end
            last_exp_acc = e_acc;
        end
    end

    initial begin
        logic [31:0] tmp;

        // Reset held two cycles with a request pending, then a zero-wait fetch.
        rst = 1'b1; inst_req = 1'b1; inst_addr = 32'hbfc0_0000; inst_size = 2'd2;
        arready = 1'b1; rvalid = 1'b1; rlast = 1'b1; rresp = 2'd0; rdata = 32'h3c08_bfc0;
        step(2);
        chk("reset_no_acc", 32'(acc_q.size()), 32'd0);
        rst = 1'b0;
        tmp = 32'(cyc);
        step(1);
        inst_req = 1'b0;
        step(2);
        chk("reset_first_acc_cycle", qat(acc_q, 0), tmp);
        chk("zw_latency", qat(dok_q, 0) - qat(acc_q, 0), 32'd2);
        chk("zw_araddr", qat(ara_q, 0), 32'hbfc0_0000);
        chk("zw_arsize", qat(ars_q, 0), 32'd2);
        chk("zw_rdata", qat(rd_q, 0), 32'h3c08_bfc0);
        chk("zw_no_berr", 32'(berr_q.size()), 32'd0);

        // Backpressure: AR stalled 3 cycles, R delayed 4 cycles, next request waiting.
        clear_logs();
        inst_req = 1'b1; inst_addr = 32'hbfc0_0100; arready = 1'b0; rvalid = 1'b0;
        step(1);
        inst_addr = 32'hbfc0_0104;
        step(3);
        arready = 1'b1;
        step(1);
        arready = 1'b0;
        step(4);
        rvalid = 1'b1; rdata = 32'h1234_5678;
        step(1);
        arready = 1'b1;
        step(1);
        inst_req = 1'b0;
        step(2);
        chk("bp_latency", qat(dok_q, 0) - qat(acc_q, 0), 32'd9);
        chk("bp_next_acc", qat(acc_q, 1) - qat(acc_q, 0), 32'd10);
        chk("bp_araddr", qat(ara_q, 0), 32'hbfc0_0100);
        chk("bp_rdata", qat(rd_q, 0), 32'h1234_5678);

        // Back-to-back fetches with inst_req held high.
        clear_logs();
        inst_req = 1'b1; inst_addr = 32'hbfc0_0000; arready = 1'b1; rvalid = 1'b1; rlast = 1'b1;
        step(1);
        inst_addr = 32'hbfc0_0004;
        step(3);
        inst_req = 1'b0;
        step(2);
        chk("b2b_acc_gap", qat(acc_q, 1) - qat(acc_q, 0), 32'd3);
        chk("b2b_dok0", qat(dok_q, 0) - qat(acc_q, 0), 32'd2);
        chk("b2b_dok1", qat(dok_q, 1) - qat(acc_q, 0), 32'd5);
        chk("b2b_araddr1", qat(ara_q, 1), 32'hbfc0_0004);

        // Bus error response still returns data, error pulses once.
        clear_logs();
        inst_req = 1'b1; inst_addr = 32'hbfc0_0200; rresp = 2'b10; rdata = 32'hcafe_f00d;
        step(1);
        inst_req = 1'b0;
        step(3);
        rresp = 2'b00;
        chk("berr_count", 32'(berr_q.size()), 32'd1);
        chk("berr_with_dok", qat(berr_q, 0), qat(dok_q, 0));
        chk("berr_rdata", qat(rd_q, 0), 32'hcafe_f00d);

        // Reset while waiting for R; a late beat must not be taken.
        clear_logs();
        inst_req = 1'b1; inst_addr = 32'hbfc0_0300; rvalid = 1'b0;
        step(1);
        inst_req = 1'b0;
        step(1);
        rst = 1'b1;
        step(1);
        rst = 1'b0; rvalid = 1'b1; rlast = 1'b1;
        step(2);
        chk("rstmid_no_dok", 32'(dok_q.size()), 32'd0);
        inst_req = 1'b1; inst_addr = 32'hbfc0_0400;
        step(1);
        inst_req = 1'b0;
        step(2);
        chk("rstmid_recover", qat(dok_q, 0) - qat(acc_q, 1), 32'd2);

        // Randomized traffic; the fetch master holds its request until accepted.
        for (int i = 0; i < 3000; i++) begin
            if (!inst_req || last_exp_acc) begin
                inst_req = ($urandom_range(0, 2) != 0);
                tmp = $urandom;
                inst_addr = tmp & 32'hffff_fffc;
                inst_size = 2'($urandom_range(0, 3));
                inst_wr = 1'($urandom_range(0, 1));
                inst_wdata = $urandom;
            end
            arready = ($urandom_range(0, 3) != 0);
            rvalid  = ($urandom_range(0, 3) != 0);
            rlast   = ($urandom_range(0, 4) != 0);
            rresp   = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            rdata   = $urandom;
            rid     = 4'($urandom_range(0, 15));
            rst     = ($urandom_range(0, 199) == 0);
            step(1);
        end
        rst = 1'b0;
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
